// File: rtl/sprite_draw_ctrl.sv
// Sprite draw controller: sequences draw, frame wait, erase and move
// phases for a 4x4 sprite, with a sweep watchdog and a frame counter.
module sprite_draw_ctrl (
    input  logic       clock,
    input  logic       resetn,
    input  logic       go,
    input  logic       stop,
    input  logic       pause,
    input  logic [2:0] colour_in,
    input  logic       pixel_done,
    input  logic       frame_done,
    output logic       draw,
    output logic       plot,
    output logic       erase_colour,
    output logic [2:0] colour_out,
    output logic       en_delay,
    output logic       en_xy,
    output logic [2:0] state,
    output logic [7:0] frame_count,
    output logic       error
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_nextState;
    logic        r_run;
    logic        w_runNext;
    logic [2:0]  r_colour;
    logic [7:0]  r_frameCount;
    logic [4:0]  r_wdog;
    logic [4:0]  w_wdogNext;
    logic        w_timeout;
    logic        r_frameDonePrev;
    logic        r_enDelay;
    logic        w_latchColour;
    logic        w_incCount;
    logic        w_clearCount;
    logic        w_inSweep;
    logic        w_enterSweep;

    // The watchdog times out on the edge where it would reach 31.
    assign w_wdogNext   = r_wdog + 5'd1;
    assign w_timeout    = (w_wdogNext == 5'd31);
    assign w_inSweep    = (r_state == S_DRAW) || (r_state == S_ERASE);
    assign w_enterSweep = (w_nextState != r_state) &&
                          ((w_nextState == S_DRAW) || (w_nextState == S_ERASE));

    // State register.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic plus the side effects each transition requests.
    always_comb begin
        w_nextState   = r_state;
        w_runNext     = r_run & ~stop;
        w_latchColour = 1'b0;
        w_incCount    = 1'b0;
        w_clearCount  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (go && !stop) begin
                    w_nextState   = S_DRAW;
                    w_runNext     = 1'b1;
                    w_latchColour = 1'b1;
                end
            end
            S_DRAW: begin
                if (pixel_done) begin
                    w_nextState = S_WAIT;
                end else if (w_timeout) begin
                    w_nextState = S_ERR;
                end
            end
            S_WAIT: begin
                if (frame_done && !r_frameDonePrev && !pause) begin
                    w_nextState = S_ERASE;
                end
            end
            S_ERASE: begin
                if (pixel_done) begin
                    w_nextState = S_MOVE;
                end else if (w_timeout) begin
                    w_nextState = S_ERR;
                end
            end
            S_MOVE: begin
                w_incCount    = 1'b1;
                w_latchColour = 1'b1;
                w_nextState   = w_runNext ? S_DRAW : S_IDLE;
            end
            S_ERR: begin
                w_runNext = r_run;
                if (go) begin
                    w_nextState   = S_DRAW;
                    w_runNext     = 1'b1;
                    w_latchColour = 1'b1;
                    w_clearCount  = 1'b1;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // Run flag, colour latch, frame counter and frame_done history.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_run           <= 1'b0;
            r_colour        <= 3'b000;
            r_frameCount    <= 8'd0;
            r_frameDonePrev <= 1'b0;
        end else begin
            r_run           <= w_runNext;
            r_frameDonePrev <= frame_done;
            if (w_latchColour) begin
                r_colour <= colour_in;
            end
            if (w_clearCount) begin
                r_frameCount <= 8'd0;
            end else if (w_incCount) begin
                r_frameCount <= r_frameCount + 8'd1;
            end
        end
    end

    // Sweep watchdog: restarts on sweep entry, counts while sweeping.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_wdog <= 5'd0;
        end else if (w_enterSweep) begin
            r_wdog <= 5'd0;
        end else if (w_inSweep) begin
            r_wdog <= w_wdogNext;
        end
    end

    // Frame-delay enable is registered so pause never reaches an output combinationally.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            r_enDelay <= 1'b0;
        end else begin
            r_enDelay <= (w_nextState == S_WAIT) && !pause;
        end
    end

    assign draw         = w_inSweep;
    assign plot         = w_inSweep;
    assign erase_colour = (r_state == S_ERASE);
    assign colour_out   = (r_state == S_DRAW) ? r_colour : 3'b000;
    assign en_delay     = r_enDelay;
    assign en_xy        = (r_state == S_MOVE);
    assign state        = r_state;
    assign frame_count  = r_frameCount;
    assign error        = (r_state == S_ERR);

endmodule
